ddr_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the DDR controller.
- Port 0 is the display/framebuffer fetch path and has priority. Port 1 is the cell-update engine and may read or write.
- Issues one single-word transaction at a time to the controller and returns read data or write completion to the owning port.
- A starvation guard keeps port 0 from locking out port 1 indefinitely.

---
 rtl/ddr_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_ddr_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_arbiter
//
// Two-port arbiter and single-transaction sequencer in front of the DDR
// controller. Port 0 (display fetch) has priority. Port 1 (cell update) is
// forced through after STARVE_LIMIT consecutive port-0 grants taken while it
// was waiting. One single-word command is in flight at a time. Read data or
// write completion is returned to the owning port as a one-cycle done pulse.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Adds the TIMEOUT parameter, a read-return/ack watchdog and the sticky
//   err output. Without it the arbiter waits indefinitely for the controller.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   p0_*/p1_*          requester ports: req (level, held until done), we,
//                      addr, wdata in; done (1-cycle pulse), rdata out
//   ddr_req/we/addr/wdata  command to controller, held until ddr_ack
//   ddr_ack            controller accepted the command
//   ddr_rvalid/rdata   controller read return
//   grant              owning port (0/1), meaningful while busy
//   busy               a transaction is in flight
//   err                (ARB_TIMEOUT_EN only) sticky watchdog expiry flag
// ---------------------------------------------------------------------------
module ddr_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ddr_req,
    output logic              ddr_we,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic [DATA_W-1:0] ddr_wdata,
    input  logic              ddr_ack,
    input  logic              ddr_rvalid,
    input  logic [DATA_W-1:0] ddr_rdata,
    output logic              grant,
    output logic              busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    // state   | meaning
    // IDLE    | arbitrate sampled requests, latch winner's command
    // ISSUE   | ddr_req held until ddr_ack
    // WAIT_RD | read accepted, waiting for ddr_rvalid
    // DONE    | pulse owner's done, deliver read data, release
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t            state;
    logic [7:0]        starve_cnt;
    logic [DATA_W-1:0] rd_buf;
    logic              rd_load;   // rd_buf holds data for the owner's rdata
    logic              p1_wins;
    logic              wd_hit;

    assign p1_wins = p1_req && (!p0_req || (starve_cnt == STARVE_MAX));

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

    logic [9:0] wd_cnt;

    assign wd_hit = ((state == ISSUE) || (state == WAIT_RD)) && (wd_cnt == WD_LIMIT);

    // Clearing in IDLE restarts the count on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if ((state == ISSUE) || (state == WAIT_RD)) begin
                wd_cnt <= wd_cnt + 10'd1;
            end
            if (wd_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_buf     <= '0;
            rd_load    <= 1'b0;
            p0_done    <= 1'b0;
            p0_rdata   <= '0;
            p1_done    <= 1'b0;
            p1_rdata   <= '0;
            ddr_req    <= 1'b0;
            ddr_we     <= 1'b0;
            ddr_addr   <= '0;
            ddr_wdata  <= '0;
            grant      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!p1_req) begin
                        starve_cnt <= '0;
                    end
                    if (p0_req || p1_req) begin
                        ddr_req <= 1'b1;
                        busy    <= 1'b1;
                        rd_load <= 1'b0;
                        state   <= ISSUE;
                        if (p1_wins) begin
                            grant      <= 1'b1;
                            ddr_we     <= p1_we;
                            ddr_addr   <= p1_addr;
                            ddr_wdata  <= p1_wdata;
                            starve_cnt <= '0;
                        end else begin
                            grant     <= 1'b0;
                            ddr_we    <= p0_we;
                            ddr_addr  <= p0_addr;
                            ddr_wdata <= p0_wdata;
                            if (p1_req && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 8'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (wd_hit) begin
                        ddr_req <= 1'b0;
                        rd_buf  <= '1;
                        rd_load <= 1'b1;
                        state   <= DONE;
                    end else if (ddr_ack) begin
                        ddr_req <= 1'b0;
                        if (ddr_we) begin
                            state <= DONE;
                        end else if (ddr_rvalid) begin
                            // controller returned data together with the ack
                            rd_buf  <= ddr_rdata;
                            rd_load <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (wd_hit) begin
                        rd_buf  <= '1;
                        rd_load <= 1'b1;
                        state   <= DONE;
                    end else if (ddr_rvalid) begin
                        rd_buf  <= ddr_rdata;
                        rd_load <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    // rdata changes only together with the done pulse
                    if (grant) begin
                        p1_done <= 1'b1;
                        if (rd_load) begin
                            p1_rdata <= rd_buf;
                        end
                    end else begin
                        p0_done <= 1'b1;
                        if (rd_load) begin
                            p0_rdata <= rd_buf;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: a transaction-level timeline model (grant edge,
// ack delay, read latency) predicts every output each cycle; directed
// scenarios pin literal values; a random phase exercises arbitration,
// starvation and stray controller strobes.
module tb_ddr_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SL = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          rq    [2];
    logic          rwe   [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd   [2];

    logic          p0_done, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ddr_req, ddr_we;
    logic [AW-1:0] ddr_addr;
    logic [DW-1:0] ddr_wdata;
    logic          ddr_ack    = 1'b0;
    logic          ddr_rvalid = 1'b0;
    logic [DW-1:0] ddr_rdata  = '0;
    logic          grant, busy;
`ifdef ARB_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    ddr_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(rq[0]), .p0_we(rwe[0]), .p0_addr(raddr[0]), .p0_wdata(rwd[0]),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(rq[1]), .p1_we(rwe[1]), .p1_addr(raddr[1]), .p1_wdata(rwd[1]),
        .p1_done(p1_done), .p1_rdata(p1_rdata),
        .ddr_req(ddr_req), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata),
        .ddr_ack(ddr_ack), .ddr_rvalid(ddr_rvalid), .ddr_rdata(ddr_rdata),
        .grant(grant), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    int nchk = 0;
    int nerr = 0;
    int t    = 0;

    // model: one transaction described by its grant edge and delays
    bit            act = 0;
    int            g, a_d, r_d, c_e, d_e, req_len, own, scnt;
    bit            m_we, m_to;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    bit            dn_flag;
    int            dn_port;
    int            ndone = 0;

    logic          e_req, e_we, e_grant, e_busy, e_d0, e_d1, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_r0, e_r1;

    // stimulus policy
    int            force_a   = -1;
    int            force_r   = -1;
    bit            fdata_en  = 0;
    logic [DW-1:0] fdata     = '0;
    int            keep_mode = 2;   // 0 random, 1 keep request, 2 drop after done
    bit            gen_en    = 0;
    bit            stray_en  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, t, got, exp);
        end
    endtask

    task automatic model_edge();
        int span;
        t++;
        e_d0    = 1'b0;
        e_d1    = 1'b0;
        dn_flag = 1'b0;
        if (rst) begin
            act = 0; scnt = 0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_grant = 0; e_busy = 0;
            e_r0 = '0; e_r1 = '0; e_err = 0;
        end else if (act) begin
            e_req = (t < g + req_len);
            if (t == c_e && m_to) e_err = 1'b1;
            if (t == d_e) begin
                e_busy  = 1'b0;
                act     = 0;
                dn_flag = 1'b1;
                dn_port = own;
                ndone++;
                if (own == 1) e_d1 = 1'b1; else e_d0 = 1'b1;
                if (!m_we || m_to) begin
                    if (own == 1) e_r1 = m_to ? {DW{1'b1}} : m_rd;
                    else          e_r0 = m_to ? {DW{1'b1}} : m_rd;
                end
            end
        end else begin
            if (!rq[1]) scnt = 0;
            if (rq[0] || rq[1]) begin
                own = (rq[1] && (!rq[0] || scnt == SL)) ? 1 : 0;
                if (own == 1) scnt = 0;
                else if (rq[1] && scnt < SL) scnt++;
                m_we   = rwe[own];
                m_addr = raddr[own];
                m_wd   = rwd[own];
                m_rd   = fdata_en ? fdata : DW'($urandom);
                a_d    = (force_a > 0)  ? force_a : int'($urandom_range(6, 1));
                r_d    = (force_r >= 0) ? force_r : int'($urandom_range(5, 0));
                span   = a_d + (m_we ? 0 : r_d);
                m_to   = 0;
`ifdef ARB_TIMEOUT_EN
                if (span >= TO + 1) begin
                    m_to = 1;
                    span = TO + 1;
                end
`endif
                req_len = (a_d < span) ? a_d : span;
                g   = t;
                c_e = g + span;
                d_e = c_e + 1;
                act = 1;
                e_req = 1; e_busy = 1; e_grant = (own == 1);
                e_we = m_we; e_addr = m_addr; e_wdata = m_wd;
            end
        end
    endtask

    task automatic drive_next();
        int e;
        bit real_rv;
        bit keep;
        e = t + 1;
        if (act && e <= g + a_d) ddr_ack = (e == g + a_d);
        else                     ddr_ack = stray_en && ($urandom_range(7, 0) == 0);
        real_rv = 0;
        if (act && !m_we && e >= g + a_d && e <= g + a_d + r_d) begin
            real_rv    = (e == g + a_d + r_d);
            ddr_rvalid = real_rv;
        end else begin
            ddr_rvalid = stray_en && ($urandom_range(7, 0) == 0);
        end
        ddr_rdata = real_rv ? m_rd : DW'($urandom);
        for (int n = 0; n < 2; n++) begin
            if (rq[n]) begin
                if (dn_flag && dn_port == n) begin
                    keep = (keep_mode == 1) || (keep_mode == 0 && $urandom_range(2, 0) == 0);
                    if (!keep) rq[n] = 1'b0;
                end
            end else if (gen_en) begin
                rwe[n]   = 1'($urandom_range(1, 0));
                raddr[n] = AW'($urandom);
                rwd[n]   = DW'($urandom);
                if ($urandom_range(2, 0) == 0) rq[n] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("ddr_req",   32'(ddr_req),   32'(e_req));
        chk("ddr_we",    32'(ddr_we),    32'(e_we));
        chk("ddr_addr",  32'(ddr_addr),  32'(e_addr));
        chk("ddr_wdata", 32'(ddr_wdata), 32'(e_wdata));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("p0_done",   32'(p0_done),   32'(e_d0));
        chk("p1_done",   32'(p1_done),   32'(e_d1));
        chk("p0_rdata",  32'(p0_rdata),  32'(e_r0));
        chk("p1_rdata",  32'(p1_rdata),  32'(e_r1));
        if (e_busy) chk("grant", 32'(grant), 32'(e_grant));
`ifdef ARB_TIMEOUT_EN
        chk("err", 32'(err), 32'(e_err));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        drive_next();
        @(negedge clk);
        compare();
    endtask

    task automatic set_req(input int n, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[n] = 1'b1; rwe[n] = we; raddr[n] = a; rwd[n] = d;
    endtask

    initial begin
        int   ncmd, done_k, nd0, nd1, nreq, nd, guard;
        logic prev;
        int   seq [18];

        for (int n = 0; n < 2; n++) begin
            rq[n] = 1'b0; rwe[n] = 1'b0; raddr[n] = '0; rwd[n] = '0;
        end

        // reset
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_ddr_req",  32'(ddr_req),  0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_p0_done",  32'(p0_done),  0);
        chk("rst_p1_rdata", 32'(p1_rdata), 0);
        chk("rst_ddr_addr", 32'(ddr_addr), 0);
        rst = 1'b0;
        cycle();

        // port-0 read of 0x000010, ack after 1, data 0xBEEF 4 later
        force_a = 1; force_r = 4; fdata_en = 1; fdata = 16'hBEEF;
        set_req(0, 1'b0, 24'h000010, 16'h0);
        ncmd = 0; done_k = 0; nd0 = 0; nd1 = 0; prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (ddr_req && !prev) begin
                ncmd++;
                chk("t1_cmd_addr", 32'(ddr_addr), 32'h10);
                chk("t1_cmd_we",   32'(ddr_we),   0);
            end
            prev = ddr_req;
            if (p0_done) begin
                nd0++;
                if (done_k == 0) begin
                    done_k = k;
                    chk("t1_rdata",      32'(p0_rdata), 32'hBEEF);
                    chk("t1_model_rd",   32'(e_r0),     32'hBEEF);
                    chk("t1_busy_done",  32'(busy),     0);
                end
            end
        end
        chk("t1_cmd_count",  32'(ncmd),   1);
        chk("t1_done_cycle", 32'(done_k), 7);
        chk("t1_done_width", 32'(nd0),    1);

        // port-1 write 0x1234 -> 0x00ABCD, ack 6 edges after grant
        force_a = 6; force_r = 0;
        set_req(1, 1'b1, 24'h00ABCD, 16'h1234);
        nreq = 0; done_k = 0; nd0 = 0;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (ddr_req) begin
                nreq++;
                chk("t2_we",    32'(ddr_we),    1);
                chk("t2_wdata", 32'(ddr_wdata), 32'h1234);
                chk("t2_addr",  32'(ddr_addr),  32'hABCD);
            end
            if (p1_done && done_k == 0) done_k = k;
            if (p0_done) nd0++;
        end
        chk("t2_req_cycles", 32'(nreq),   6);
        chk("t2_done_cycle", 32'(done_k), 8);
        chk("t2_no_p0_done", 32'(nd0),    0);

        // ack and rvalid together -> minimum latency
        force_a = 1; force_r = 0; fdata = 16'h5A5A;
        set_req(0, 1'b0, 24'h005A5A, 16'h0);
        done_k = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (p0_done && done_k == 0) begin
                done_k = k;
                chk("t3_rdata", 32'(p0_rdata), 32'h5A5A);
            end
        end
        chk("t3_done_cycle", 32'(done_k), 3);

        // reset while waiting for read data, then late rvalid
        force_a = 1; force_r = 8; fdata = 16'h7777;
        set_req(0, 1'b0, 24'h000077, 16'h0);
        repeat (3) cycle();
        chk("t4_busy_before_rst", 32'(busy), 1);
        rst = 1'b1; rq[0] = 1'b0;
        cycle();
        rst = 1'b0;
        chk("t4_rst_busy",     32'(busy),     0);
        chk("t4_rst_p0_rdata", 32'(p0_rdata), 0);
        chk("t4_rst_ddr_we",   32'(ddr_we),   0);
        chk("t4_rst_grant",    32'(grant),    0);
        ddr_rvalid = 1'b1; ddr_rdata = 16'h7777;
        nd0 = 0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (p0_done || p1_done) nd0++;
        end
        chk("t4_no_done", 32'(nd0), 0);
        chk("t4_rdata_dropped", 32'(p0_rdata), 0);
        force_a = 2; force_r = 1; fdata = 16'h4321;
        set_req(1, 1'b0, 24'h000123, 16'h0);
        done_k = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (p1_done && done_k == 0) begin
                done_k = k;
                chk("t4_next_rdata", 32'(p1_rdata), 32'h4321);
            end
        end
        chk("t4_next_done_cycle", 32'(done_k), 5);

        // both ports held high: P0 x8 then P1, repeating
        force_a = -1; force_r = -1; fdata_en = 0; stray_en = 1; keep_mode = 1;
        set_req(0, 1'b0, 24'h000100, 16'h0);
        set_req(1, 1'b0, 24'h000200, 16'h0);
        nd = 0; guard = 0;
        while (nd < 18 && guard < 400) begin
            cycle();
            guard++;
            if (p0_done || p1_done) begin
                seq[nd] = p1_done ? 1 : 0;
                nd++;
            end
        end
        chk("starve_completions", 32'(nd), 18);
        for (int i = 0; i < nd; i++) chk("starve_seq", 32'(seq[i]), 32'((i % 9) == 8));
        keep_mode = 2;
        repeat (30) cycle();

`ifdef ARB_TIMEOUT_EN
        // controller never returns data
        stray_en = 0; force_a = 1; force_r = 1000;
        set_req(0, 1'b0, 24'h000400, 16'h0);
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (p0_done && done_k == 0) begin
                done_k = k;
                chk("to_rdata", 32'(p0_rdata), 32'hFFFF);
                chk("to_err",   32'(err),      1);
            end
        end
        chk("to_done_window", 32'(done_k >= 21 && done_k <= 23), 1);
        force_a = -1; force_r = -1;
`endif

        // random traffic
        nd = ndone;
        gen_en = 1; stray_en = 1; keep_mode = 0;
        repeat (3000) cycle();
        gen_en = 0; keep_mode = 2;
        repeat (40) cycle();
        chk("rand_activity", 32'((ndone - nd) > 200), 1);
        chk("rand_idle_end", 32'(busy), 0);
`ifdef ARB_TIMEOUT_EN
        chk("err_sticky", 32'(err), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
